// File: rtl/if_map_writer_pkg.sv
// Shared definitions for the ifmap writer: default sizes, FSM encoding and a
// small width helper used when sizing derived parameters.
package if_map_writer_pkg;

  localparam int unsigned IfMapHeightDef = 8;
  localparam int unsigned MaxRowDef      = 2;
  localparam int unsigned DataWidthDef   = 16;

  // StIdle: next transfer opens a row. StFill: a row is in progress.
  typedef enum logic [0:0] {StIdle, StFill} wr_state_e;

  // clog2 that never returns 0, so a one-entry structure still gets a 1-bit pointer.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_len_table.sv
// Row length table: stores the word count of each completed row.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset (clears all entries)
//   we          - write strobe
//   waddr/wdata - write slot and row length
//   raddr/rdata - asynchronous read of a slot
module row_len_table
  import if_map_writer_pkg::*;
#(
  parameter int unsigned DEPTH     = MaxRowDef,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PTR_WIDTH = clog2_min1(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [PTR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [PTR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_map_writer.sv
// Ifmap writer: accepts a row-framed word stream, writes it into a circular
// ifmap buffer and reports row start/end addresses to the reader's row table.
// Space is reclaimed a whole row at a time when the reader releases the oldest row.
// Ports:
//   clk, rst                       - clock, asynchronous active-low reset
//   in_data/in_valid/in_last       - incoming word stream, in_last marks end of row
//   in_ready                       - word accepted this cycle when in_valid is high
//   release_row                    - reader finished the oldest stored row
//   wen/waddr/wdata                - buffer write port
//   ld_start/start_out             - row-table start address strobe
//   ld_end/end_out                 - row-table end address strobe (one past last word)
//   row_wptr                       - row-table slot being written
//   rows_valid                     - number of complete rows stored
//   full/empty                     - buffer occupancy flags
module if_map_writer
  import if_map_writer_pkg::*;
#(
  parameter int unsigned IF_MAP_HEIGHT = IfMapHeightDef,
  parameter int unsigned MAX_ROW       = MaxRowDef,
  parameter int unsigned DATA_WIDTH    = DataWidthDef,
  parameter int unsigned ADD_WIDTH     = clog2_min1(IF_MAP_HEIGHT),
  parameter int unsigned ROW_PTR_WIDTH = clog2_min1(MAX_ROW)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     release_row,
  output logic                     wen,
  output logic [ADD_WIDTH-1:0]     waddr,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic                     ld_start,
  output logic [ADD_WIDTH-1:0]     start_out,
  output logic                     ld_end,
  output logic [ADD_WIDTH-1:0]     end_out,
  output logic [ROW_PTR_WIDTH-1:0] row_wptr,
  output logic [ROW_PTR_WIDTH:0]   rows_valid,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned CntW = ADD_WIDTH + 1;
  localparam int unsigned RvW  = ROW_PTR_WIDTH + 1;

  localparam logic [ADD_WIDTH-1:0]     LastAddr = ADD_WIDTH'(IF_MAP_HEIGHT - 1);
  localparam logic [ROW_PTR_WIDTH-1:0] LastRow  = ROW_PTR_WIDTH'(MAX_ROW - 1);
  localparam logic [CntW-1:0]          Height   = CntW'(IF_MAP_HEIGHT);
  localparam logic [RvW-1:0]           MaxRows  = RvW'(MAX_ROW);

  wr_state_e              state_q, state_d;
  logic [ADD_WIDTH-1:0]     wptr_q, wptr_d, wptr_inc;
  logic [ROW_PTR_WIDTH-1:0] row_wptr_q, row_wptr_d;
  logic [ROW_PTR_WIDTH-1:0] row_rptr_q, row_rptr_d;
  logic [CntW-1:0]          occ_q, occ_d;
  logic [RvW-1:0]           rows_valid_q, rows_valid_d;
  logic [CntW-1:0]          row_len_q, row_len_d, cur_len;
  logic [CntW-1:0]          rel_len;
  logic                     xfer, last_xfer, rel;

  row_len_table #(
    .DEPTH    (MAX_ROW),
    .WIDTH    (CntW),
    .PTR_WIDTH(ROW_PTR_WIDTH)
  ) u_len_table (
    .clk  (clk),
    .rst  (rst),
    .we   (last_xfer),
    .waddr(row_wptr_q),
    .wdata(cur_len),
    .raddr(row_rptr_q),
    .rdata(rel_len)
  );

  // Handshake depends on registered state only, never on in_valid.
  assign in_ready  = (occ_q != Height) && (rows_valid_q < MaxRows);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && in_last;
  assign rel       = release_row && (rows_valid_q != '0);

  // Explicit compare keeps the wrap correct for non-power-of-two heights.
  assign wptr_inc = (wptr_q == LastAddr) ? '0 : wptr_q + ADD_WIDTH'(1);

  // Length of the current row including this word; row_len_q is 0 in StIdle.
  assign cur_len = (row_len_q == Height) ? Height : row_len_q + CntW'(1);

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    row_wptr_d   = row_wptr_q;
    row_rptr_d   = row_rptr_q;
    occ_d        = occ_q;
    rows_valid_d = rows_valid_q;
    row_len_d    = row_len_q;

    if (xfer) begin
      wptr_d = wptr_inc;
      occ_d  = occ_d + CntW'(1);
      if (in_last) begin
        state_d      = StIdle;
        row_len_d    = '0;
        row_wptr_d   = (row_wptr_q == LastRow) ? '0 : row_wptr_q + ROW_PTR_WIDTH'(1);
        rows_valid_d = rows_valid_d + RvW'(1);
      end else begin
        state_d   = StFill;
        row_len_d = cur_len;
      end
    end

    // Applied after the transfer so a simultaneous write and release both land.
    if (rel) begin
      occ_d        = occ_d - rel_len;
      rows_valid_d = rows_valid_d - RvW'(1);
      row_rptr_d   = (row_rptr_q == LastRow) ? '0 : row_rptr_q + ROW_PTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      row_wptr_q   <= '0;
      row_rptr_q   <= '0;
      occ_q        <= '0;
      rows_valid_q <= '0;
      row_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      row_wptr_q   <= row_wptr_d;
      row_rptr_q   <= row_rptr_d;
      occ_q        <= occ_d;
      rows_valid_q <= rows_valid_d;
      row_len_q    <= row_len_d;
    end
  end

  assign wen        = xfer;
  assign waddr      = wptr_q;
  assign wdata      = in_data;
  assign ld_start   = xfer && (state_q == StIdle);
  assign start_out  = wptr_q;
  assign ld_end     = last_xfer;
  assign end_out    = wptr_inc;
  assign row_wptr   = row_wptr_q;
  assign rows_valid = rows_valid_q;
  assign full       = (occ_q == Height);
  assign empty      = (occ_q == '0);

endmodule

// File: tb/tb_if_map_writer.sv
// Directed bench for if_map_writer at default sizes (8 entries, 2 rows, 16-bit data).
module tb_if_map_writer;
  import if_map_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_last, in_ready, release_row;
  logic        wen, ld_start, ld_end, full, empty;
  logic [2:0]  waddr, start_out, end_out;
  logic [15:0] wdata;
  logic [0:0]  row_wptr;
  logic [1:0]  rows_valid;

  int n_checks = 0;
  int n_fail   = 0;

  if_map_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .release_row(release_row),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .ld_start   (ld_start),
    .start_out  (start_out),
    .ld_end     (ld_end),
    .end_out    (end_out),
    .row_wptr   (row_wptr),
    .rows_valid (rows_valid),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_last     = 1'b0;
    release_row = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  // Present one word for a single cycle and check the write-side strobes.
  task automatic push(input logic [15:0] d, input logic last, input logic [2:0] exp_addr,
                      input logic exp_start, input logic exp_end, input logic [2:0] exp_eo);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    check_eq("wen", 32'(wen), 32'd1);
    check_eq("waddr", 32'(waddr), 32'(exp_addr));
    check_eq("wdata", 32'(wdata), 32'(d));
    check_eq("ld_start", 32'(ld_start), 32'(exp_start));
    if (exp_start) check_eq("start_out", 32'(start_out), 32'(exp_addr));
    check_eq("ld_end", 32'(ld_end), 32'(exp_end));
    if (exp_end) check_eq("end_out", 32'(end_out), 32'(exp_eo));
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    in_data = '0;
    idle_in();
    #2;
    // Values held while reset is asserted
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_rows_valid", 32'(rows_valid), 32'd0);
    check_eq("rst_row_wptr", 32'(row_wptr), 32'd0);
    check_eq("rst_wen", 32'(wen), 32'd0);
    do_reset();

    // A: one 4-word row
    for (int i = 0; i < 4; i++) begin
      push(16'hA000 + 16'(i), (i == 3), 3'(i), (i == 0), (i == 3), 3'd4);
    end
    check_eq("a_rows_valid", 32'(rows_valid), 32'd1);
    check_eq("a_occ", 32'(dut.occ_q), 32'd4);
    check_eq("a_row_wptr", 32'(row_wptr), 32'd1);
    check_eq("a_empty", 32'(empty), 32'd0);

    // B: second 4-word row fills the buffer; end address wraps to 0
    for (int i = 0; i < 4; i++) begin
      push(16'hB000 + 16'(i), (i == 3), 3'(4 + i), (i == 0), (i == 3), 3'd0);
    end
    check_eq("b_full", 32'(full), 32'd1);
    check_eq("b_in_ready", 32'(in_ready), 32'd0);
    check_eq("b_rows_valid", 32'(rows_valid), 32'd2);
    in_valid = 1'b1;
    in_data  = 16'hC000;
    #1;
    check_eq("b_held_wen0", 32'(wen), 32'd0);
    step();
    check_eq("b_held_wen1", 32'(wen), 32'd0);
    release_row = 1'b1;
    #1;
    check_eq("b_rel_cycle_wen", 32'(wen), 32'd0);
    step();
    release_row = 1'b0;
    #1;
    check_eq("b_occ", 32'(dut.occ_q), 32'd4);
    check_eq("b_rows_after", 32'(rows_valid), 32'd1);
    check_eq("b_ready_after", 32'(in_ready), 32'd1);
    check_eq("b_wen_after", 32'(wen), 32'd1);
    check_eq("b_waddr_wrap", 32'(waddr), 32'd0);
    check_eq("b_start_wrap", 32'(start_out), 32'd0);
    step();
    idle_in();

    // C: row-table limit stalls input with space left in the buffer
    do_reset();
    push(16'h0C00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0);
    push(16'h0C01, 1'b1, 3'd1, 1'b0, 1'b1, 3'd2);
    push(16'h0C02, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0);
    push(16'h0C03, 1'b1, 3'd3, 1'b0, 1'b1, 3'd4);
    check_eq("c_rows_valid", 32'(rows_valid), 32'd2);
    check_eq("c_full", 32'(full), 32'd0);
    check_eq("c_in_ready", 32'(in_ready), 32'd0);
    check_eq("c_row_wptr", 32'(row_wptr), 32'd0);
    in_valid = 1'b1;
    #1;
    check_eq("c_blocked_wen", 32'(wen), 32'd0);
    in_valid    = 1'b0;
    release_row = 1'b1;
    step();
    release_row = 1'b0;
    check_eq("c_ready_after", 32'(in_ready), 32'd1);
    check_eq("c_rows_after", 32'(rows_valid), 32'd1);
    check_eq("c_occ_after", 32'(dut.occ_q), 32'd2);
    check_eq("c_row_rptr", 32'(dut.row_rptr_q), 32'd1);

    // D: last word of a 3-word row together with release of a 2-word row
    push(16'h0D00, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0);
    push(16'h0D01, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0);
    check_eq("d_occ_before", 32'(dut.occ_q), 32'd4);
    in_valid    = 1'b1;
    in_data     = 16'h0D02;
    in_last     = 1'b1;
    release_row = 1'b1;
    #1;
    check_eq("d_wen", 32'(wen), 32'd1);
    check_eq("d_waddr", 32'(waddr), 32'd6);
    check_eq("d_ld_end", 32'(ld_end), 32'd1);
    check_eq("d_end_out", 32'(end_out), 32'd7);
    step();
    idle_in();
    check_eq("d_occ", 32'(dut.occ_q), 32'd3);
    check_eq("d_rows_valid", 32'(rows_valid), 32'd1);
    check_eq("d_row_wptr", 32'(row_wptr), 32'd1);
    check_eq("d_row_rptr", 32'(dut.row_rptr_q), 32'd0);

    // E: one-word row at address 7; end address wraps to 0, state stays idle
    push(16'h0E00, 1'b1, 3'd7, 1'b1, 1'b1, 3'd0);
    check_eq("e_state", 32'(dut.state_q), 32'(StIdle));
    check_eq("e_rows_valid", 32'(rows_valid), 32'd2);
    check_eq("e_occ", 32'(dut.occ_q), 32'd4);

    // F: reset in the middle of a row
    do_reset();
    push(16'h0F00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0);
    push(16'h0F01, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0);
    push(16'h0F02, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0);
    check_eq("f_state_fill", 32'(dut.state_q), 32'(StFill));
    rst = 1'b0;
    #1;
    check_eq("f_ld_end", 32'(ld_end), 32'd0);
    check_eq("f_occ", 32'(dut.occ_q), 32'd0);
    check_eq("f_wptr", 32'(dut.wptr_q), 32'd0);
    check_eq("f_row_len", 32'(dut.row_len_q), 32'd0);
    check_eq("f_rows_valid", 32'(rows_valid), 32'd0);
    check_eq("f_row_wptr", 32'(row_wptr), 32'd0);
    check_eq("f_empty", 32'(empty), 32'd1);
    check_eq("f_full", 32'(full), 32'd0);
    check_eq("f_in_ready", 32'(in_ready), 32'd1);
    check_eq("f_state", 32'(dut.state_q), 32'(StIdle));
    step();
    rst = 1'b1;
    #1;
    push(16'h0F10, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
